// File: rtl/jk_excitation_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excitation_seq_if
//  Description : Bundle of the target-stream handshake and JK excitation
//                outputs of jk_excitation_seq.
//                master : stimulus side (drives in_valid/in_bit/advance/
//                         use_toggle, observes everything else)
//                slave  : the sequencer itself
//  Signals     : in_valid, in_bit   - target Q bit and its qualifier
//                in_ready           - FIFO has room
//                advance            - permit one pop/excitation
//                use_toggle         - encode a change as jk=11
//                j, k               - registered JK drive
//                q_model            - predicted downstream Q
//                busy               - INIT state or FIFO non-empty
//                flips              - saturating count of non-hold excitations
//  Revision    : 1.0  initial release
// ============================================================================
interface jk_excitation_seq_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             advance;
   logic             use_toggle;
   logic             j;
   logic             k;
   logic             q_model;
   logic             busy;
   logic [CNT_W-1:0] flips;

   modport master (
      output in_valid, in_bit, advance, use_toggle,
      input  in_ready, j, k, q_model, busy, flips
   );

   modport slave (
      input  in_valid, in_bit, advance, use_toggle,
      output in_ready, j, k, q_model, busy, flips
   );
endinterface
`default_nettype wire

// File: rtl/jk_excitation_seq.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excitation_seq
//  Description : Inverse JK flip-flop. Buffers a stream of target Q bits in a
//                small FIFO and, one bit per advance, drives j/k so that a
//                downstream JK flop (reset to 0) follows the stream.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high reset
//                bus    - jk_excitation_seq_if.slave (handshake + JK drive)
//  Parameters  : DEPTH  - FIFO entries, power of two, >= 2
//                CNT_W  - width of the saturating flip counter
//  Revision    : 1.0  initial release
// ============================================================================
module jk_excitation_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   jk_excitation_seq_if.slave    bus
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_q;
   logic [DEPTH-1:0]   fifo_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W:0]     count_q;
   logic               j_q;
   logic               k_q;
   logic               q_model_q;
   logic [CNT_W-1:0]   flips_q;

   logic               do_push;
   logic               do_pop;
   logic               head_bit;
   logic [1:0]         exc_d;

   // in_ready comes only from the registered count, so a pop on the same
   // edge never lets a full FIFO accept a new bit.
   assign bus.in_ready = (count_q < DEPTH_C);
   assign bus.busy     = (state_q == ST_INIT) || (count_q != '0);

   assign do_push  = bus.in_valid && bus.in_ready;
   assign do_pop   = (state_q == ST_RUN) && bus.advance && (count_q != '0);
   assign head_bit = fifo_q[rd_ptr_q];

   // Excitation that moves the downstream flop from q_model to the head bit.
   always_comb begin
      exc_d = 2'b00;
      if (head_bit != q_model_q) begin
         exc_d = bus.use_toggle ? 2'b11 : {head_bit, ~head_bit};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_INIT;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         j_q       <= 1'b0;
         k_q       <= 1'b1;
         q_model_q <= 1'b0;
         flips_q   <= '0;
      end else begin
         if (do_push) begin
            fifo_q[wr_ptr_q] <= bus.in_bit;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end

         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         case (state_q)
            // INIT leaves jk=01 from reset in place for one cycle, clearing
            // the downstream flop, then falls through to RUN.
            ST_INIT: begin
               state_q <= ST_RUN;
               j_q     <= 1'b0;
               k_q     <= 1'b0;
            end
            default: begin
               state_q <= ST_RUN;
               if (do_pop) begin
                  {j_q, k_q} <= exc_d;
                  q_model_q  <= head_bit;
                  if ((exc_d != 2'b00) && (flips_q != '1)) begin
                     flips_q <= flips_q + 1'b1;
                  end
               end else begin
                  j_q <= 1'b0;
                  k_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.j       = j_q;
   assign bus.k       = k_q;
   assign bus.q_model = q_model_q;
   assign bus.flips   = flips_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_excitation_seq
//  Description : Self-checking bench for jk_excitation_seq. A queue-based
//                reference model and a downstream JK flop run alongside the
//                DUT; directed scenarios are followed by random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jk_excitation_seq;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int MAXF  = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   jk_excitation_seq_if #(.CNT_W(CNT_W)) bus ();

   jk_excitation_seq #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Downstream JK flop driven by the DUT.
   logic ds_q;
   always @(posedge clk) begin
      if (reset) ds_q <= 1'b0;
      else       ds_q <= (bus.j & ~ds_q) | (~bus.k & ds_q);
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   bit   mq[$];
   bit   m_init = 1'b1;
   bit   m_q    = 1'b0;
   bit [1:0] m_jk = 2'b01;
   int   m_flips = 0;
   bit   rst_seen = 1'b0;

   logic [1:0] o_jk;
   logic       o_q;

   // One clock: drive inputs, advance the model, check after the edge.
   task automatic cycle(input bit r, input bit v, input bit b, input bit adv, input bit tog);
      logic qm_before;
      bit   push, pop, t;
      reset          = r;
      bus.in_valid   = v;
      bus.in_bit     = b;
      bus.advance    = adv;
      bus.use_toggle = tog;
      qm_before      = bus.q_model;

      if (r) begin
         mq.delete();
         m_init  = 1'b1;
         m_jk    = 2'b01;
         m_q     = 1'b0;
         m_flips = 0;
      end else begin
         push = v && (mq.size() < DEPTH);
         pop  = !m_init && adv && (mq.size() != 0);
         m_jk = 2'b00;
         if (pop) begin
            t = mq.pop_front();
            if (t != m_q) begin
               m_jk = tog ? 2'b11 : (t ? 2'b10 : 2'b01);
               if (m_flips < MAXF) m_flips++;
            end
            m_q = t;
         end
         if (push) mq.push_back(b);
         m_init = 1'b0;
      end

      @(posedge clk);
      @(negedge clk);
      o_jk = {bus.j, bus.k};
      o_q  = bus.q_model;
      chk("jk",       32'(o_jk),       32'(m_jk));
      chk("q_model",  32'(o_q),        32'(m_q));
      chk("flips",    32'(bus.flips),  32'(m_flips));
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      chk("busy",     32'(bus.busy),   32'(m_init || (mq.size() != 0)));
      if (!r && rst_seen) chk("downstream_q", 32'(ds_q), 32'(qm_before));
      if (r) rst_seen = 1'b1;
   endtask

   bit       s2b[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [1:0] s2e[4] = '{2'b10, 2'b01, 2'b00, 2'b10};
   logic [1:0] s3e[4] = '{2'b11, 2'b11, 2'b00, 2'b11};
   bit       s4b[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_bit     = 1'b0;
      bus.advance    = 1'b0;
      bus.use_toggle = 1'b0;
      @(negedge clk);

      // Reset and INIT
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("s1_init_jk",   32'(o_jk), 32'(2'b01));
      chk("s1_init_busy", 32'(bus.busy), 32'd1);
      chk("s1_ready",     32'(bus.in_ready), 32'd1);
      cycle(0, 0, 0, 0, 0);
      chk("s1_run_jk",    32'(o_jk), 32'(2'b00));
      chk("s1_run_busy",  32'(bus.busy), 32'd0);
      chk("s1_qm",        32'(o_q), 32'd0);

      // Set/reset encoding
      for (int i = 0; i < 5; i++) begin
         cycle(0, i < 4, (i < 4) ? s2b[i] : 1'b0, 1, 0);
         if (i >= 1) begin
            chk($sformatf("s2_jk%0d", i), 32'(o_jk), 32'(s2e[i-1]));
            chk($sformatf("s2_qm%0d", i), 32'(o_q),  32'(s2b[i-1]));
         end
      end
      chk("s2_flips", 32'(bus.flips), 32'd3);

      // Toggle encoding
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, i < 4, (i < 4) ? s2b[i] : 1'b0, 1, 1);
         if (i >= 1) begin
            chk($sformatf("s3_jk%0d", i), 32'(o_jk), 32'(s3e[i-1]));
            chk($sformatf("s3_qm%0d", i), 32'(o_q),  32'(s2b[i-1]));
         end
      end
      chk("s3_flips", 32'(bus.flips), 32'd3);

      // Fill the FIFO with advance low, hold the 5th bit, then drain
      for (int i = 0; i < 4; i++) cycle(0, 1, s4b[i], 0, 0);
      chk("s4_full_ready", 32'(bus.in_ready), 32'd0);
      cycle(0, 1, s4b[4], 0, 0);
      chk("s4_still_full", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cycle(0, i < 2, s4b[4], 1, 0);
         chk($sformatf("s4_order%0d", i), 32'(o_q), 32'(s4b[i]));
      end
      chk("s4_empty_busy", 32'(bus.busy), 32'd0);

      // Reset with bits queued
      for (int i = 0; i < 3; i++) cycle(0, 1, ~s4b[i], 0, 0);
      chk("s5_queued_busy", 32'(bus.busy), 32'd1);
      cycle(1, 0, 0, 0, 0);
      chk("s5_init_busy", 32'(bus.busy), 32'd1);
      cycle(0, 0, 0, 1, 0);
      chk("s5_run_busy", 32'(bus.busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 0);
         chk($sformatf("s5_no_emit%0d", i), 32'(o_jk), 32'(2'b00));
      end
      chk("s5_flips", 32'(bus.flips), 32'd0);

      // Random co-simulation
      for (int i = 0; i < 400; i++) begin
         cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
